// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;
  localparam int AW_DEF = 12;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } own_t;

  localparam logic [3:0] BE_FULL = 4'hF;
endpackage

// File: rtl/sram_arbiter_if.sv
// Core-side request ports plus SRAM pins of the arbiter, bundled with modports.
interface sram_arbiter_if #(
  parameter int AW = sram_arb_pkg::AW_DEF,
  parameter int DW = sram_arb_pkg::DW_DEF
);
  // Requesters hold REQ and all qualifiers stable until the matching GNT is
  // seen high in the same cycle; GNT is the ready, REQ the valid, and a read
  // returns data exactly one cycle after GNT with a one-cycle RVALID strobe.
  logic          I_REQ;
  logic [AW-1:0] I_ADDR;
  logic          I_GNT;
  logic          I_RVALID;
  logic [DW-1:0] I_RDATA;
  logic          D_REQ;
  logic          D_WE;
  logic [3:0]    D_BE;
  logic [AW-1:0] D_ADDR;
  logic [DW-1:0] D_WDATA;
  logic          D_GNT;
  logic          D_RVALID;
  logic [DW-1:0] D_RDATA;
  logic          M_CSN;
  logic [AW-1:0] M_ADDR;
  logic          M_WE;
  logic [3:0]    M_BE;
  logic [DW-1:0] M_DI;
  logic [DW-1:0] M_DO;

  modport master (
    output I_REQ, I_ADDR, D_REQ, D_WE, D_BE, D_ADDR, D_WDATA, M_DO,
    input  I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
    input  M_CSN, M_ADDR, M_WE, M_BE, M_DI
  );

  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_WE, D_BE, D_ADDR, D_WDATA, M_DO,
    output I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
    output M_CSN, M_ADDR, M_WE, M_BE, M_DI
  );
endinterface

// File: rtl/sram_arb_pick.sv
// Combinational winner selection. SRAM_ARB_RR_EN selects round-robin,
// otherwise fixed data priority with a fetch starvation escape.
import sram_arb_pkg::*;

module sram_arb_pick #(
  parameter int STARVE_MAX = 4,
  parameter int SW         = 3
) (
  input  logic          i_req,
  input  logic          d_req,
`ifdef SRAM_ARB_RR_EN
  input  own_t          last_own,
`else
  input  logic [SW-1:0] starve,
`endif
  output logic          i_gnt,
  output logic          d_gnt
);
  logic fetch_first;

`ifdef SRAM_ARB_RR_EN
  assign fetch_first = (last_own == OWN_D);
`else
  assign fetch_first = (starve == SW'(STARVE_MAX));
`endif

  assign i_gnt = i_req && (!d_req || fetch_first);
  assign d_gnt = d_req && !i_gnt;
endmodule

// File: rtl/sram_arbiter.sv
// Shares one synchronous SRAM between fetch and data ports; one access per cycle.
// Build option: SRAM_ARB_RR_EN switches arbitration to round-robin.
import sram_arb_pkg::*;

module sram_arbiter #(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  sram_arbiter_if.slave    bus,
  output own_t             dbg_rd_own
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic          i_gnt;
  logic          d_gnt;
  own_t          rd_own;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] di_mux;

`ifdef SRAM_ARB_RR_EN
  own_t last_own;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)      last_own <= OWN_I;
    else if (i_gnt) last_own <= OWN_I;
    else if (d_gnt) last_own <= OWN_D;
  end

  sram_arb_pick u_pick (
    .i_req    (bus.I_REQ),
    .d_req    (bus.D_REQ),
    .last_own (last_own),
    .i_gnt    (i_gnt),
    .d_gnt    (d_gnt)
  );
`else
  logic [SW-1:0] starve;

  // Counts data wins while fetch is waiting; saturates at STARVE_MAX.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                                   starve <= '0;
    else if (i_gnt || !bus.I_REQ)                starve <= '0;
    else if (d_gnt && starve != SW'(STARVE_MAX)) starve <= starve + 1'b1;
  end

  sram_arb_pick #(.STARVE_MAX(STARVE_MAX), .SW(SW)) u_pick (
    .i_req  (bus.I_REQ),
    .d_req  (bus.D_REQ),
    .starve (starve),
    .i_gnt  (i_gnt),
    .d_gnt  (d_gnt)
  );
`endif

  // Records which port owns the data returning in the next cycle.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                     rd_own <= OWN_NONE;
    else if (i_gnt)                rd_own <= OWN_I;
    else if (d_gnt && !bus.D_WE)   rd_own <= OWN_D;
    else                           rd_own <= OWN_NONE;
  end

  always_comb begin
    bus.M_CSN = 1'b1;
    bus.M_WE  = 1'b0;
    bus.M_BE  = 4'h0;
    addr_mux  = '0;
    di_mux    = '0;
    if (i_gnt) begin
      bus.M_CSN = 1'b0;
      bus.M_BE  = BE_FULL;
      addr_mux  = bus.I_ADDR;
    end else if (d_gnt) begin
      bus.M_CSN = 1'b0;
      bus.M_WE  = bus.D_WE;
      bus.M_BE  = bus.D_BE;
      addr_mux  = bus.D_ADDR;
      di_mux    = bus.D_WDATA;
    end
  end

  assign bus.M_ADDR   = addr_mux;
  assign bus.M_DI     = di_mux;
  assign bus.I_GNT    = i_gnt;
  assign bus.D_GNT    = d_gnt;
  assign bus.I_RVALID = (rd_own == OWN_I);
  assign bus.D_RVALID = (rd_own == OWN_D);
  assign bus.I_RDATA  = bus.M_DO;
  assign bus.D_RDATA  = bus.M_DO;
  assign dbg_rd_own   = rd_own;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 4096x32 SRAM model.
import sram_arb_pkg::*;

module tb_sram_arbiter;
  logic CLK;
  logic RSTN;
  own_t dbg_rd_own;
  int   n_cmp;
  int   n_err;
  logic [31:0] mem [0:4095];

  sram_arbiter_if #(.AW(12), .DW(32)) bus ();

  sram_arbiter #(.AW(12), .DW(32), .STARVE_MAX(4)) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .bus        (bus),
    .dbg_rd_own (dbg_rd_own)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // synchronous SRAM model with byte enables
  always @(posedge CLK) begin
    if (bus.M_CSN === 1'b0) begin
      if (bus.M_WE) begin
        for (int b = 0; b < 4; b++)
          if (bus.M_BE[b]) mem[bus.M_ADDR][8*b +: 8] <= bus.M_DI[8*b +: 8];
      end else begin
        bus.M_DO <= mem[bus.M_ADDR];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.I_REQ   = 1'b0;
    bus.I_ADDR  = '0;
    bus.D_REQ   = 1'b0;
    bus.D_WE    = 1'b0;
    bus.D_BE    = 4'h0;
    bus.D_ADDR  = '0;
    bus.D_WDATA = '0;
  endtask

  task automatic do_reset();
    idle();
    RSTN = 1'b0;
    repeat (2) cyc();
    chk("rst_i_rvalid", 32'(bus.I_RVALID), 32'd0);
    chk("rst_d_rvalid", 32'(bus.D_RVALID), 32'd0);
    chk("rst_rd_own",   32'(dbg_rd_own),   32'(OWN_NONE));
    chk("rst_csn",      32'(bus.M_CSN),    32'd1);
    chk("rst_be",       32'(bus.M_BE),     32'd0);
    chk("rst_gnts",     32'({bus.I_GNT, bus.D_GNT}), 32'd0);
    RSTN = 1'b1;
    cyc();
  endtask

  task automatic d_write(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
    bus.D_REQ = 1'b1; bus.D_WE = 1'b1; bus.D_BE = be; bus.D_ADDR = a; bus.D_WDATA = d;
    #1;
    chk("wr_gnt",  32'({bus.I_GNT, bus.D_GNT}), 32'b01);
    chk("wr_pins", {bus.M_CSN, bus.M_WE, bus.M_BE, 14'd0, bus.M_ADDR}, {1'b0, 1'b1, be, 14'd0, a});
    chk("wr_di",   bus.M_DI, d);
    cyc();
    idle();
    chk("wr_no_rvalid", 32'({bus.I_RVALID, bus.D_RVALID}), 32'd0);
  endtask

  task automatic f_read(input logic [11:0] a, input logic [31:0] exp);
    bus.I_REQ = 1'b1; bus.I_ADDR = a;
    #1;
    chk("fr_gnt",  32'({bus.I_GNT, bus.D_GNT}), 32'b10);
    chk("fr_pins", {bus.M_CSN, bus.M_WE, bus.M_BE, 14'd0, bus.M_ADDR}, {1'b0, 1'b0, 4'hF, 14'd0, a});
    cyc();
    idle();
    chk("fr_rvalid", 32'({bus.I_RVALID, bus.D_RVALID}), 32'b10);
    chk("fr_rdata",  bus.I_RDATA, exp);
    cyc();
    chk("fr_rvalid_drop", 32'(bus.I_RVALID), 32'd0);
  endtask

  task automatic d_read(input logic [11:0] a, input logic [31:0] exp);
    bus.D_REQ = 1'b1; bus.D_WE = 1'b0; bus.D_ADDR = a;
    #1;
    chk("dr_gnt", 32'({bus.I_GNT, bus.D_GNT}), 32'b01);
    cyc();
    idle();
    chk("dr_rvalid", 32'({bus.I_RVALID, bus.D_RVALID}), 32'b01);
    chk("dr_rdata",  bus.D_RDATA, exp);
    cyc();
  endtask

  logic [9:0] exp_i_seq;

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.M_DO = '0;
    do_reset();

    // preload through the data port
    d_write(12'h010, 4'hF, 32'hE1A00000);
    d_write(12'h020, 4'hF, 32'h11223344);

    // fetch alone
    f_read(12'h010, 32'hE1A00000);

    // partial write followed immediately by a read of the same word
    d_write(12'h020, 4'b0011, 32'hAABBCCDD);
    d_read(12'h020, 32'h1122CCDD);

    // idle window
    for (int k = 0; k < 10; k++) begin
      chk("idle_csn", 32'(bus.M_CSN), 32'd1);
      chk("idle_be",  32'(bus.M_BE),  32'd0);
      chk("idle_rv",  32'({bus.I_RVALID, bus.D_RVALID}), 32'd0);
      cyc();
    end
    f_read(12'h010, 32'hE1A00000);
    d_read(12'h020, 32'h1122CCDD);

    // reset in the cycle after a granted fetch read
    bus.I_REQ = 1'b1; bus.I_ADDR = 12'h010;
    #1;
    chk("rr_gnt", 32'(bus.I_GNT), 32'd1);
    cyc();
    idle();
    RSTN = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(bus.I_RVALID), 32'd0);
    chk("mid_rst_own",    32'(dbg_rd_own),   32'(OWN_NONE));
    cyc();
    chk("mid_rst_rvalid2", 32'(bus.I_RVALID), 32'd0);
    RSTN = 1'b1;
    cyc();
    chk("post_rst_rvalid", 32'(bus.I_RVALID), 32'd0);
    f_read(12'h010, 32'hE1A00000);

    // both request continuously
`ifdef SRAM_ARB_RR_EN
    exp_i_seq = 10'b1010101010;  // bit k = 1 means fetch wins cycle k
`else
    exp_i_seq = 10'b1000010000;
`endif
    do_reset();
    bus.I_REQ = 1'b1; bus.I_ADDR = 12'h010;
    bus.D_REQ = 1'b1; bus.D_WE = 1'b0; bus.D_ADDR = 12'h020;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("seq_gnt_%0d", k), 32'({bus.I_GNT, bus.D_GNT}),
          32'({exp_i_seq[k], !exp_i_seq[k]}));
      if (k > 0) begin
        chk($sformatf("seq_rv_%0d", k), 32'({bus.I_RVALID, bus.D_RVALID}),
            32'({exp_i_seq[k-1], !exp_i_seq[k-1]}));
        if (exp_i_seq[k-1]) chk("seq_irdata", bus.I_RDATA, 32'hE1A00000);
        else                chk("seq_drdata", bus.D_RDATA, 32'h1122CCDD);
      end
      cyc();
    end
    idle();
    #1;
    chk("seq_last_rv", 32'({bus.I_RVALID, bus.D_RVALID}),
        32'({exp_i_seq[9], !exp_i_seq[9]}));
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
